// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stage enables, flushes, ecall drain-to-halt, perf counters.
// Enables/flushes are combinational from state and inputs; state and counters update on the next edge.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_LEN      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs1_addr,
    input  logic [4:0]         id_rs2_addr,
    input  logic [1:0]         id_rs1,
    input  logic [1:0]         id_rs2,
    input  logic [2:0]         id_br,
    input  logic [2:0]         id_mem_fn,
    input  logic               id_ecall,
    input  logic [4:0]         ex_rd_addr,
    input  logic [1:0]         ex_wb_sel,
    input  logic               ex_br_taken,
    input  logic               dmem_busy,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               id_ex_en,
    output logic               ex_mem_en,
    output logic               mem_wb_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               halt,
    output logic [CNT_LEN-1:0] stall_cnt,
    output logic [CNT_LEN-1:0] flush_cnt
);

    // Field encodings mirror define.vh
    localparam logic [1:0] RS1_RS1  = 2'd1;
    localparam logic [1:0] RS2_RS2  = 2'd1;
    localparam logic [2:0] BR_BEQ   = 3'd1;
    localparam logic [2:0] BR_BNE   = 3'd2;
    localparam logic [2:0] BR_BLT   = 3'd3;
    localparam logic [2:0] BR_BGE   = 3'd4;
    localparam logic [2:0] BR_BLTU  = 3'd5;
    localparam logic [2:0] BR_BGEU  = 3'd6;
    localparam logic [2:0] MEM_SW   = 3'd4;
    localparam logic [2:0] MEM_SH   = 3'd5;
    localparam logic [2:0] MEM_SB   = 3'd6;
    localparam logic [1:0] WB_MEM   = 3'd2;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    logic [1:0]         state_q, state_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [CNT_LEN-1:0] stall_q, stall_d;
    logic [CNT_LEN-1:0] flush_q, flush_d;

    logic is_cond_br, uses_rs1, uses_rs2, load_use;

    always_comb begin
        is_cond_br = (id_br == BR_BEQ)  || (id_br == BR_BNE) || (id_br == BR_BLT) ||
                     (id_br == BR_BGE)  || (id_br == BR_BLTU) || (id_br == BR_BGEU);
        uses_rs1   = (id_rs1 == RS1_RS1) || is_cond_br;
        uses_rs2   = (id_rs2 == RS2_RS2) || is_cond_br ||
                     (id_mem_fn == MEM_SB) || (id_mem_fn == MEM_SH) || (id_mem_fn == MEM_SW);
        load_use   = (ex_wb_sel == WB_MEM) && (ex_rd_addr != 5'd0) &&
                     ((uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halt        = 1'b0;

        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_busy) begin
                        // Whole pipe freezes; a taken branch in EX is re-presented later.
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                        stall_d   = stall_q + CNT_LEN'(1);
                    end else if (ex_br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_d     = flush_q + CNT_LEN'(1);
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_d     = stall_q + CNT_LEN'(1);
                    end else if (id_ecall) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_d     = DW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (dmem_busy) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                        stall_d   = stall_q + CNT_LEN'(1);
                    end else begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        if (drain_q <= DW'(1)) begin
                            state_d = ST_HALT;
                        end else begin
                            drain_d = drain_q - DW'(1);
                        end
                    end
                end
                default: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    halt      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard/drain/reset/wrap steps, then random traffic against an instruction-level model.
module tb_pipeline_ctrl;

    localparam int DC = 3;

    localparam logic [1:0] RS1_X = 2'd0, RS1_RS1 = 2'd1, RS1_PC = 2'd2;
    localparam logic [1:0] RS2_X = 2'd0, RS2_RS2 = 2'd1, RS2_IMI = 2'd2, RS2_IMS = 2'd3;
    localparam logic [2:0] BR_X = 3'd0, BR_J = 3'd7;
    localparam logic [2:0] MEM_X = 3'd0;
    localparam logic [1:0] WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC4 = 2'd3;

    localparam int C_R = 0, C_IMM = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_LUI = 6, C_ECALL = 7;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    logic [2:0] br_codes [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [2:0] ld_codes [3] = '{3'd1, 3'd2, 3'd3};
    logic [2:0] st_codes [3] = '{3'd6, 3'd5, 3'd4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic [1:0] id_rs1, id_rs2, ex_wb_sel;
    logic [2:0] id_br, id_mem_fn;
    logic       id_ecall, ex_br_taken, dmem_busy;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halt;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4, halt4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    logic [7:0] outs, outs4;
    assign outs  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halt};
    assign outs4 = {pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4, halt4};

    pipeline_ctrl #(.DRAIN_CYCLES(DC), .CNT_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_br(id_br), .id_mem_fn(id_mem_fn), .id_ecall(id_ecall),
        .ex_rd_addr(ex_rd_addr), .ex_wb_sel(ex_wb_sel), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(DC), .CNT_LEN(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_br(id_br), .id_mem_fn(id_mem_fn), .id_ecall(id_ecall),
        .ex_rd_addr(ex_rd_addr), .ex_wb_sel(ex_wb_sel), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .halt(halt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: instruction class decides operand use; mode plus remaining drain slots.
    int          m_mode = M_RUN;
    int          m_left = 0;
    logic [31:0] m_stall = '0, m_flush = '0;
    bit          m_u1, m_u2, m_exld;
    logic [31:0] saved;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input int cls, input logic [4:0] a1, input logic [4:0] a2, input int sub);
        id_rs1_addr = a1; id_rs2_addr = a2;
        id_rs1 = RS1_X; id_rs2 = RS2_X; id_br = BR_X; id_mem_fn = MEM_X; id_ecall = 1'b0;
        m_u1 = 0; m_u2 = 0;
        case (cls)
            C_R:   begin id_rs1 = RS1_RS1; id_rs2 = RS2_RS2; m_u1 = 1; m_u2 = 1; end
            C_IMM: begin id_rs1 = RS1_RS1; id_rs2 = RS2_IMI; m_u1 = 1; end
            C_LD:  begin id_rs1 = RS1_RS1; id_rs2 = RS2_IMI; id_mem_fn = ld_codes[sub % 3]; m_u1 = 1; end
            C_ST:  begin id_rs1 = RS1_RS1; id_rs2 = RS2_IMS; id_mem_fn = st_codes[sub % 3]; m_u1 = 1; m_u2 = 1; end
            C_BR:  begin id_rs1 = RS1_PC; id_rs2 = RS2_IMS; id_br = br_codes[sub % 6]; m_u1 = 1; m_u2 = 1; end
            C_JAL: begin id_rs1 = RS1_PC; id_rs2 = RS2_IMI; id_br = BR_J; end
            C_LUI: begin id_rs2 = RS2_IMI; end
            default: id_ecall = 1'b1;
        endcase
    endtask

    task automatic set_ex(input bit ld, input logic [4:0] rd);
        m_exld = ld;
        ex_rd_addr = rd;
        ex_wb_sel = ld ? WB_MEM : (rd[0] ? WB_PC4 : WB_ALU);
    endtask

    function automatic bit m_load_use();
        return m_exld && (ex_rd_addr != 5'd0) &&
               ((m_u1 && id_rs1_addr == ex_rd_addr) || (m_u2 && id_rs2_addr == ex_rd_addr));
    endfunction

    function automatic logic [7:0] m_out();
        if (rst)              return 8'b0000_0000;
        if (m_mode == M_HALT) return 8'b0000_0001;
        if (dmem_busy)        return 8'b0000_0000;
        if (m_mode == M_DRAIN) return 8'b0111_1100;
        if (ex_br_taken)      return 8'b1111_1110;
        if (m_load_use())     return 8'b0011_1010;
        if (id_ecall)         return 8'b0111_1100;
        return 8'b1111_1000;
    endfunction

    task automatic m_step();
        if (rst) begin
            m_mode = M_RUN; m_left = 0; m_stall = '0; m_flush = '0;
        end else if (m_mode == M_RUN) begin
            if (dmem_busy)          m_stall++;
            else if (ex_br_taken)   m_flush++;
            else if (m_load_use())  m_stall++;
            else if (id_ecall) begin m_mode = M_DRAIN; m_left = DC; end
        end else if (m_mode == M_DRAIN) begin
            if (dmem_busy) m_stall++;
            else begin
                m_left--;
                if (m_left == 0) m_mode = M_HALT;
            end
        end
    endtask

    task automatic expect_outs(input string tag, input logic [7:0] exp);
        #1;
        check(tag, {24'd0, outs}, {24'd0, exp});
    endtask

    // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        check("outs", {24'd0, outs}, {24'd0, m_out()});
        check("outs4", {24'd0, outs4}, {24'd0, m_out()});
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        check("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, m_stall[3:0]});
        check("flush_cnt4", {28'd0, flush_cnt4}, {28'd0, m_flush[3:0]});
        m_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dmem_busy = 1'b0; ex_br_taken = 1'b0;
        set_id(C_R, 5'd1, 5'd2, 0);
        set_ex(0, 5'd0);
        @(posedge clk); #1;
        expect_outs("rst_outs", 8'b0000_0000);
        tick(); tick();
        rst = 1'b0;
        expect_outs("run_default", 8'b1111_1000);
        check("rst_stall", stall_cnt, 32'd0);
        tick();

        // lw x5 in EX, add x6,x5,x1 in ID
        set_ex(1, 5'd5); set_id(C_R, 5'd5, 5'd1, 0);
        expect_outs("lu_stall", 8'b0011_1010);
        tick();
        set_ex(0, 5'd0);
        expect_outs("lu_release", 8'b1111_1000);
        check("lu_stall_cnt", stall_cnt, 32'd1);
        tick();

        // Store and branch use rs2; addi does not
        set_ex(1, 5'd7); set_id(C_ST, 5'd2, 5'd7, 2);
        expect_outs("sw_stall", 8'b0011_1010);
        tick();
        set_ex(1, 5'd7); set_id(C_BR, 5'd3, 5'd7, 0);
        expect_outs("beq_stall", 8'b0011_1010);
        tick();
        set_ex(1, 5'd7); set_id(C_IMM, 5'd0, 5'd7, 0);
        expect_outs("addi_nostall", 8'b1111_1000);
        tick();

        // Branch beats load-use
        set_ex(1, 5'd7); set_id(C_R, 5'd7, 5'd7, 0); ex_br_taken = 1'b1;
        saved = m_stall;
        expect_outs("br_over_lu", 8'b1111_1110);
        tick();
        ex_br_taken = 1'b0; set_ex(0, 5'd0);
        check("br_stall_same", stall_cnt, saved);

        // Ecall drain with one busy cycle at t+2
        saved = m_stall;
        set_id(C_ECALL, 5'd0, 5'd0, 0);
        expect_outs("ecall_t0", 8'b0111_1100); tick();
        set_id(C_R, 5'd0, 5'd0, 0);
        expect_outs("drain_t1", 8'b0111_1100); tick();
        dmem_busy = 1'b1;
        expect_outs("drain_busy_t2", 8'b0000_0000); tick();
        dmem_busy = 1'b0;
        expect_outs("drain_t3", 8'b0111_1100); tick();
        expect_outs("drain_t4", 8'b0111_1100); tick();
        expect_outs("halt_t5", 8'b0000_0001); tick();
        ex_br_taken = 1'b1;
        expect_outs("halt_t6", 8'b0000_0001); tick();
        ex_br_taken = 1'b0;
        check("drain_stall", stall_cnt, saved + 32'd1);

        // Reset from HALT
        rst = 1'b1;
        expect_outs("halt_rst", 8'b0000_0000); tick();
        rst = 1'b0;
        expect_outs("halt_rst_run", 8'b1111_1000);
        check("halt_rst_flush", flush_cnt, 32'd0);
        tick();

        // Reset mid-drain
        set_id(C_ECALL, 5'd0, 5'd0, 0); tick();
        set_id(C_R, 5'd0, 5'd0, 0); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        expect_outs("drain_rst_run", 8'b1111_1000);
        check("drain_rst_stall", stall_cnt, 32'd0);
        tick();

        // 17 busy cycles wrap the 4-bit counter to 1; x0 load-use adds nothing
        dmem_busy = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        dmem_busy = 1'b0;
        check("wrap4", {28'd0, stall_cnt4}, 32'd1);
        set_ex(1, 5'd0); set_id(C_R, 5'd0, 5'd0, 0);
        expect_outs("x0_nostall", 8'b1111_1000);
        tick();
        check("x0_wrap4", {28'd0, stall_cnt4}, 32'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            dmem_busy   = ($urandom_range(0, 5) == 0);
            ex_br_taken = ($urandom_range(0, 7) == 0);
            set_ex($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 24) == 0)
                set_id(C_ECALL, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 0);
            else
                set_id(int'($urandom_range(0, 6)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
